nand_way_scheduler: RTL and testbench

Per-channel scheduler that shares one NAND channel bus (DQ/DQS/CLE/ALE/WE/RE) among NUM_WAYS ways, each selected by its own CE and reporting its own R/B.
- Accepts one operation per way from the upstream way queues.
- Grants the channel bus round-robin to ways whose R/B reads ready.
- Hands the granted operation to the channel bus executor.
- Tracks the way's post-transfer busy period with a timeout, then returns a completion.
- One instance per NAND channel (CH0, CH1).

---
 rtl/nand_way_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_nand_way_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_way_scheduler.sv
// Per-channel NAND way scheduler: round-robin grant of the shared channel bus
// among ready ways, then per-way tWB wait and busy tracking with timeout.
module nand_way_scheduler #(
  parameter int                  NUM_WAYS     = 8,
  parameter int                  WAY_IDX_W    = 3,
  parameter int                  TWB_CYCLES   = 16,
  parameter int                  TO_WIDTH     = 24,
  parameter logic [TO_WIDTH-1:0] BUSY_TIMEOUT = 24'hFFFFFF
) (
  input  logic                  iSystemClock,
  input  logic                  iReset,
  input  logic [NUM_WAYS-1:0]   iWayReqValid,
  output logic [NUM_WAYS-1:0]   oWayReqReady,
  input  logic [2*NUM_WAYS-1:0] iWayReqOpcode,
  output logic [NUM_WAYS-1:0]   oWayCmplValid,
  output logic [2*NUM_WAYS-1:0] oWayCmplStatus,
  input  logic [NUM_WAYS-1:0]   iReadyBusy,
  output logic [NUM_WAYS-1:0]   oCE_n,
  output logic                  oExecValid,
  input  logic                  iExecReady,
  output logic [1:0]            oExecOpcode,
  output logic [WAY_IDX_W-1:0]  oExecWay,
  input  logic                  iExecDone
);

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_PEND = 3'd1,
    W_XFER = 3'd2,
    W_WB   = 3'd3,
    W_BUSY = 3'd4,
    W_CMPL = 3'd5
  } way_state_t;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_REQ  = 2'd1,
    CH_XFER = 2'd2
  } ch_state_t;

  localparam logic [TO_WIDTH-1:0] CNT_ONE  = TO_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] TWB_LAST = TO_WIDTH'(TWB_CYCLES - 1);
  localparam logic [NUM_WAYS-1:0] WAY_ONE  = NUM_WAYS'(1);
  localparam logic [1:0]          OP_STAT  = 2'b11;
  localparam logic [1:0]          ST_OK    = 2'b00;
  localparam logic [1:0]          ST_TOUT  = 2'b10;

  way_state_t          r_way_state [NUM_WAYS];
  logic [1:0]          r_way_op    [NUM_WAYS];
  logic [TO_WIDTH-1:0] r_way_cnt   [NUM_WAYS];

  logic [NUM_WAYS-1:0]   r_rb_meta;
  logic [NUM_WAYS-1:0]   r_rb_sync;
  logic [NUM_WAYS-1:0]   r_req_ready;
  logic [NUM_WAYS-1:0]   r_cmpl_valid;
  logic [2*NUM_WAYS-1:0] r_cmpl_status;
  logic [NUM_WAYS-1:0]   r_ce_n;

  ch_state_t             r_ch_state;
  logic                  r_exec_valid;
  logic [1:0]            r_exec_op;
  logic [WAY_IDX_W-1:0]  r_exec_way;
  logic [WAY_IDX_W-1:0]  r_ptr;

  logic [NUM_WAYS-1:0]   w_elig;
  logic [NUM_WAYS-1:0]   w_grant_oh;
  logic [NUM_WAYS-1:0]   w_accept;
  logic [NUM_WAYS-1:0]   w_done;
  logic                  w_found;
  logic [WAY_IDX_W-1:0]  w_pick;
  logic [WAY_IDX_W-1:0]  w_idx;

  assign oWayReqReady   = r_req_ready;
  assign oWayCmplValid  = r_cmpl_valid;
  assign oWayCmplStatus = r_cmpl_status;
  assign oCE_n          = r_ce_n;
  assign oExecValid     = r_exec_valid;
  assign oExecOpcode    = r_exec_op;
  assign oExecWay       = r_exec_way;

  // Accept and done strobes are steered only to the currently granted way.
  assign w_grant_oh = WAY_ONE << r_exec_way;
  assign w_accept   = ((r_ch_state == CH_REQ) && iExecReady) ? w_grant_oh : {NUM_WAYS{1'b0}};
  assign w_done     = ((r_ch_state == CH_XFER) && iExecDone) ? w_grant_oh : {NUM_WAYS{1'b0}};

  always_comb begin
    w_elig = {NUM_WAYS{1'b0}};
    for (int i = 0; i < NUM_WAYS; i++) begin
      w_elig[i] = (r_way_state[i] == W_PEND) && r_rb_sync[i];
    end
  end

  // Round-robin scan starts just past the last granted way.
  always_comb begin
    w_found = 1'b0;
    w_pick  = {WAY_IDX_W{1'b0}};
    w_idx   = {WAY_IDX_W{1'b0}};
    for (int k = 1; k <= NUM_WAYS; k++) begin
      w_idx = WAY_IDX_W'((int'(r_ptr) + k) % NUM_WAYS);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_rb_meta <= {NUM_WAYS{1'b0}};
      r_rb_sync <= {NUM_WAYS{1'b0}};
    end else begin
      r_rb_meta <= iReadyBusy;
      r_rb_sync <= r_rb_meta;
    end
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_req_ready   <= {NUM_WAYS{1'b1}};
      r_cmpl_valid  <= {NUM_WAYS{1'b0}};
      r_cmpl_status <= {(2*NUM_WAYS){1'b0}};
      for (int i = 0; i < NUM_WAYS; i++) begin
        r_way_state[i] <= W_IDLE;
        r_way_op[i]    <= 2'b00;
        r_way_cnt[i]   <= {TO_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        r_cmpl_valid[i] <= 1'b0;
        case (r_way_state[i])
          W_IDLE: begin
            if (iWayReqValid[i]) begin
              r_way_op[i]    <= iWayReqOpcode[2*i +: 2];
              r_way_state[i] <= W_PEND;
              r_req_ready[i] <= 1'b0;
            end
          end
          W_PEND: begin
            if (w_accept[i]) begin
              r_way_state[i] <= W_XFER;
            end
          end
          W_XFER: begin
            if (w_done[i]) begin
              if (r_way_op[i] == OP_STAT) begin
                r_way_state[i]           <= W_CMPL;
                r_cmpl_valid[i]          <= 1'b1;
                r_cmpl_status[2*i +: 2]  <= ST_OK;
              end else begin
                r_way_state[i] <= W_WB;
                r_way_cnt[i]   <= {TO_WIDTH{1'b0}};
              end
            end
          end
          W_WB: begin
            if (r_way_cnt[i] == TWB_LAST) begin
              r_way_state[i] <= W_BUSY;
              r_way_cnt[i]   <= {TO_WIDTH{1'b0}};
            end else begin
              r_way_cnt[i] <= r_way_cnt[i] + CNT_ONE;
            end
          end
          W_BUSY: begin
            // Timeout fires on the edge where the busy count reaches BUSY_TIMEOUT.
            r_way_cnt[i] <= r_way_cnt[i] + CNT_ONE;
            if (r_rb_sync[i]) begin
              r_way_state[i]          <= W_CMPL;
              r_cmpl_valid[i]         <= 1'b1;
              r_cmpl_status[2*i +: 2] <= ST_OK;
            end else if ((r_way_cnt[i] + CNT_ONE) == BUSY_TIMEOUT) begin
              r_way_state[i]          <= W_CMPL;
              r_cmpl_valid[i]         <= 1'b1;
              r_cmpl_status[2*i +: 2] <= ST_TOUT;
            end
          end
          W_CMPL: begin
            r_way_state[i] <= W_IDLE;
            r_req_ready[i] <= 1'b1;
          end
          default: begin
            r_way_state[i] <= W_IDLE;
            r_req_ready[i] <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_ch_state   <= CH_IDLE;
      r_exec_valid <= 1'b0;
      r_exec_op    <= 2'b00;
      r_exec_way   <= {WAY_IDX_W{1'b0}};
      r_ptr        <= WAY_IDX_W'(NUM_WAYS - 1);
      r_ce_n       <= {NUM_WAYS{1'b1}};
    end else begin
      case (r_ch_state)
        CH_IDLE: begin
          if (w_found) begin
            r_exec_way   <= w_pick;
            r_exec_op    <= r_way_op[w_pick];
            r_ptr        <= w_pick;
            r_exec_valid <= 1'b1;
            r_ce_n       <= ~(WAY_ONE << w_pick);
            r_ch_state   <= CH_REQ;
          end
        end
        CH_REQ: begin
          if (iExecReady) begin
            r_exec_valid <= 1'b0;
            r_ch_state   <= CH_XFER;
          end
        end
        CH_XFER: begin
          if (iExecDone) begin
            r_ce_n     <= {NUM_WAYS{1'b1}};
            r_ch_state <= CH_IDLE;
          end
        end
        default: begin
          r_exec_valid <= 1'b0;
          r_ce_n       <= {NUM_WAYS{1'b1}};
          r_ch_state   <= CH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_way_scheduler.sv
// Directed bench for nand_way_scheduler (8 ways, BUSY_TIMEOUT overridden to 50).
module tb_nand_way_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req_valid;
  logic [7:0]  req_ready;
  logic [15:0] req_op;
  logic [7:0]  cmpl_valid;
  logic [15:0] cmpl_status;
  logic [7:0]  rb;
  logic [7:0]  ce_n;
  logic        exec_valid;
  logic        exec_ready;
  logic [1:0]  exec_op;
  logic [2:0]  exec_way;
  logic        exec_done;

  int total = 0;
  int bad   = 0;

  nand_way_scheduler #(.BUSY_TIMEOUT(24'd50)) dut (
    .iSystemClock   (clk),
    .iReset         (rst),
    .iWayReqValid   (req_valid),
    .oWayReqReady   (req_ready),
    .iWayReqOpcode  (req_op),
    .oWayCmplValid  (cmpl_valid),
    .oWayCmplStatus (cmpl_status),
    .iReadyBusy     (rb),
    .oCE_n          (ce_n),
    .oExecValid     (exec_valid),
    .iExecReady     (exec_ready),
    .oExecOpcode    (exec_op),
    .oExecWay       (exec_way),
    .iExecDone      (exec_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    bit seen;
    logic [7:0] exp_ce;

    rst = 1'b1; req_valid = 8'h00; req_op = 16'h0000; rb = 8'hFF;
    exec_ready = 1'b1; exec_done = 1'b0;
    tick(); tick();
    check("rst_ready", req_ready, 8'hFF);
    check("rst_cmpl_valid", cmpl_valid, 8'h00);
    check("rst_status", cmpl_status, 16'h0000);
    check("rst_ce", ce_n, 8'hFF);
    check("rst_exec_valid", exec_valid, 1'b0);
    check("rst_exec_op", exec_op, 2'b00);
    check("rst_exec_way", exec_way, 3'd0);
    rst = 1'b0;
    tick(); tick(); tick();

    // Single read on way 3
    req_op[7:6] = 2'b00; req_valid = 8'h08;
    tick(); req_valid = 8'h00;
    check("t1_no_valid_t1", exec_valid, 1'b0);
    check("t1_ready3_low", req_ready[3], 1'b0);
    tick();
    check("t1_exec_valid", exec_valid, 1'b1);
    check("t1_exec_way", exec_way, 3'd3);
    check("t1_exec_op", exec_op, 2'b00);
    check("t1_ce", ce_n, 8'hF7);
    tick();
    check("t1_valid_drop", exec_valid, 1'b0);
    check("t1_ce_xfer", ce_n, 8'hF7);
    rb[3] = 1'b0;
    tick(); tick(); tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("t1_ce_release", ce_n, 8'hFF);
    seen = 1'b0;
    repeat (30) begin tick(); if (cmpl_valid != 8'h00) seen = 1'b1; end
    check("t1_no_early_cmpl", seen, 1'b0);
    rb[3] = 1'b1;
    tick(); tick();
    check("t1_cmpl_not_yet", cmpl_valid, 8'h00);
    tick();
    check("t1_cmpl_pulse", cmpl_valid, 8'h08);
    check("t1_cmpl_status", cmpl_status[7:6], 2'b00);
    tick();
    check("t1_cmpl_one_cycle", cmpl_valid, 8'h00);
    check("t1_ready_back", req_ready, 8'hFF);

    // Way 5 blocked by R/B until pin rises
    rb[5] = 1'b0;
    tick(); tick(); tick();
    req_op[11:10] = 2'b00; req_valid = 8'h20;
    tick(); req_valid = 8'h00;
    seen = 1'b0;
    repeat (6) begin tick(); if (exec_valid || ce_n != 8'hFF) seen = 1'b1; end
    check("t3_no_grant_busy", seen, 1'b0);
    rb[5] = 1'b1;
    tick(); tick();
    check("t3_grant_not_yet", exec_valid, 1'b0);
    tick();
    check("t3_grant_valid", exec_valid, 1'b1);
    check("t3_grant_way", exec_way, 3'd5);
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    n = 0;
    while (!cmpl_valid[5] && n < 40) begin tick(); n++; end
    check("t3_cmpl", cmpl_valid[5], 1'b1);
    check("t3_cmpl_status", cmpl_status[11:10], 2'b00);
    tick();

    // Program on way 1 that times out
    req_op[3:2] = 2'b01; req_valid = 8'h02;
    tick(); req_valid = 8'h00;
    tick();
    check("t4_grant_way", exec_way, 3'd1);
    check("t4_grant_op", exec_op, 2'b01);
    tick();
    rb[1] = 1'b0;
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    n = 1;
    while (!cmpl_valid[1] && n < 100) begin tick(); n++; end
    check("t4_timeout_latency", n, 67);
    check("t4_timeout_status", cmpl_status[3:2], 2'b10);
    tick();
    rb[1] = 1'b1;

    // Way 6 busy while way 2 runs a status op
    req_op[13:12] = 2'b01; req_valid = 8'h40;
    tick(); req_valid = 8'h00;
    tick();
    check("t5_way6_grant", exec_way, 3'd6);
    tick();
    rb[6] = 1'b0;
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    repeat (20) tick();
    req_op[5:4] = 2'b11; req_valid = 8'h04;
    tick(); req_valid = 8'h00;
    tick();
    check("t5_way2_grant", exec_way, 3'd2);
    check("t5_way2_op", exec_op, 2'b11);
    check("t5_way2_ce", ce_n, 8'hFB);
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("t5_status_cmpl", cmpl_valid, 8'h04);
    check("t5_status_ok", cmpl_status[5:4], 2'b00);
    tick();
    check("t5_way6_still_busy", cmpl_valid, 8'h00);
    n = 0;
    while (!cmpl_valid[6] && n < 100) begin tick(); n++; end
    check("t5_way6_cmpl", cmpl_valid[6], 1'b1);
    check("t5_way6_timeout", cmpl_status[13:12], 2'b10);
    req_op[13:12] = 2'b00; req_valid = 8'h40;
    tick(); req_valid = 8'h00;
    check("t5_req_in_cmpl_ignored", req_ready[6], 1'b1);
    tick();
    check("t5_no_grant_after", exec_valid, 1'b0);
    rb[6] = 1'b1;
    tick(); tick();

    // Done outside XFER ignored, then reset during XFER
    exec_ready = 1'b0;
    req_op[9:8] = 2'b00; req_valid = 8'h10;
    tick(); req_valid = 8'h00;
    tick();
    check("t6_grant_way4", exec_way, 3'd4);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("t6_done_in_req_ignored", exec_valid, 1'b1);
    check("t6_ce_held", ce_n, 8'hEF);
    exec_ready = 1'b1;
    tick();
    check("t6_in_xfer", exec_valid, 1'b0);
    rst = 1'b1;
    tick();
    check("t6_rst_ce", ce_n, 8'hFF);
    check("t6_rst_valid", exec_valid, 1'b0);
    check("t6_rst_ready", req_ready, 8'hFF);
    check("t6_rst_cmpl", cmpl_valid, 8'h00);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin tick(); if (cmpl_valid != 8'h00 || exec_valid) seen = 1'b1; end
    check("t6_quiet_after_rst", seen, 1'b0);

    // All eight ways at once: strict round-robin order from way 0
    req_op = 16'h0000; req_valid = 8'hFF;
    tick(); req_valid = 8'h00;
    for (int g = 0; g < 8; g++) begin
      n = 0; seen = 1'b0;
      while (!exec_valid && n < 10) begin
        if ($countones(~ce_n) > 1) seen = 1'b1;
        tick(); n++;
      end
      exp_ce = ~(8'h01 << g);
      check("t2_grant_valid", exec_valid, 1'b1);
      check("t2_grant_order", exec_way, g);
      check("t2_ce_onehot", ce_n, exp_ce);
      check("t2_ce_never_two", seen, 1'b0);
      tick(); tick(); tick(); tick();
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      check("t2_ce_gap", ce_n, 8'hFF);
    end
    repeat (30) tick();
    check("t2_all_idle", req_ready, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
